hex_entry: RTL and testbench

HEX_ENTRY -- requirements
Module: hex_entry

---
 rtl/hex_entry_pkg.sv | 19 +
 rtl/key_debounce.sv | 47 ++++
 rtl/hex_entry.sv | 89 ++++++++
 tb/tb_hex_entry.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the hex keypad entry block.
package hex_entry_pkg;

   localparam int NUM_KEYS = 3;
   localparam int DIGIT    = 0;
   localparam int ENTER    = 1;
   localparam int CLEAR    = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Debounce counter spans 0 .. cycles-1.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer, debouncer and press-edge detector for one active-low pushbutton.
module key_debounce
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic press
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          db;
   logic          db_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         db    <= 1'b1;
         db_d  <= 1'b1;
         cnt   <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         db_d  <= db;
         // Any sample that agrees with the debounced level restarts the run.
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = db_d & ~db;

endmodule

// File: rtl/hex_entry.sv
// Hex word entry from switches and three pushbuttons, with a valid/ready output port.
//
// state | meaning
// EMPTY | no submitted word pending, data_valid=0
// FULL  | data holds a word awaiting data_ready
module hex_entry
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  sw,
   input  logic        key_digit,
   input  logic        key_enter,
   input  logic        key_clear,
   output logic [31:0] entry,
   output logic [31:0] data,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        overrun
);

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] press;

   assign key_raw = {key_clear, key_enter, key_digit};

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk    (clk),
         .rst_n  (rst_n),
         .key_raw(key_raw[k]),
         .press  (press[k])
      );
   end

   out_state_t state;
   out_state_t state_nxt;
   logic       clr_ev;
   logic       ent_ev;
   logic       dig_ev;
   logic       handshake;
   logic       accept;
   logic       reject;

   always_comb begin
      clr_ev    = press[CLEAR];
      ent_ev    = press[ENTER] & ~press[CLEAR];
      dig_ev    = press[DIGIT] & ~press[ENTER] & ~press[CLEAR];
      handshake = (state == FULL) & data_ready;
      accept    = ent_ev & ((state == EMPTY) | handshake);
      reject    = ent_ev & ~accept;
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (handshake && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         entry   <= '0;
         data    <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) data <= entry;
         if (clr_ev || accept) begin
            entry <= '0;
         end else if (dig_ev) begin
            entry <= {entry[27:0], sw};
         end
         if (clr_ev) begin
            overrun <= 1'b0;
         end else if (reject) begin
            overrun <= 1'b1;
         end
      end
   end

   // Registered state only, so data_valid never follows data_ready combinationally.
   assign data_valid = (state == FULL);

endmodule

// File: tb/tb_hex_entry.sv
// Randomized scoreboard bench for hex_entry with a behavioural entry/submit model.
module tb_hex_entry;

   localparam int DC  = 4;
   localparam int LAT = DC + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  sw = 4'h0;
   logic        key_digit = 1'b1;
   logic        key_enter = 1'b1;
   logic        key_clear = 1'b1;
   logic        data_ready = 1'b0;
   logic [31:0] entry;
   logic [31:0] data;
   logic        data_valid;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_entry;
   logic [31:0] m_data;
   bit          m_valid;
   bit          m_ovr;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   hex_entry #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .key_digit (key_digit),
      .key_enter (key_enter),
      .key_clear (key_clear),
      .entry     (entry),
      .data      (data),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .overrun   (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_entry"}, entry, m_entry);
      chk({tag, "_data"}, data, m_data);
      chk({tag, "_valid"}, {31'b0, data_valid}, {31'b0, m_valid});
      chk({tag, "_overrun"}, {31'b0, overrun}, {31'b0, m_ovr});
   endtask

   // Monitor: every handshake the DUT presents must deliver the oldest submitted word.
   logic [31:0] mon_exp;
   always @(negedge clk) begin
      if (rst_n && data_valid && data_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_unexpected actual=%h expected=no_word", data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("handshake_data", data, mon_exp);
         end
      end
   end

   // Reference model for one press event, with the consumer's ready level that cycle.
   task automatic model_event(input logic [2:0] mask, input logic [3:0] swv, input bit rdy);
      bit hs;
      hs = m_valid && rdy;
      if (mask[2]) begin
         m_entry = 0;
         m_ovr   = 0;
         if (hs) m_valid = 0;
      end else if (mask[1]) begin
         if (!m_valid || hs) begin
            m_data  = m_entry;
            m_valid = 1;
            exp_q.push_back(m_entry);
            m_entry = 0;
         end else begin
            m_ovr = 1;
         end
      end else begin
         if (mask[0]) m_entry = m_entry * 16 + 32'(swv);
         if (hs) m_valid = 0;
      end
   endtask

   // mask bit0=digit, bit1=enter, bit2=clear; rdy raises data_ready in the event cycle.
   task automatic press(input logic [2:0] mask, input logic [3:0] swv, input bit rdy, input int hold);
      logic [31:0] pre_entry;
      pre_entry = m_entry;
      @(posedge clk); #1;
      sw        = swv;
      key_digit = ~mask[0];
      key_enter = ~mask[1];
      key_clear = ~mask[2];
      repeat (LAT) @(posedge clk);
      #1;
      chk("latency_early_entry", entry, pre_entry);
      if (rdy) data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      model_event(mask, swv, rdy);
      chk_all("event");
      repeat (hold) @(posedge clk);
      #1;
      chk("held_single_event", entry, m_entry);
      key_digit = 1'b1;
      key_enter = 1'b1;
      key_clear = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk_all("release");
   endtask

   task automatic consume();
      @(posedge clk); #1;
      data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      m_valid = 0;
      chk("consume_valid", {31'b0, data_valid}, 32'd0);
   endtask

   task automatic model_reset();
      m_entry = 0;
      m_data  = 0;
      m_valid = 0;
      m_ovr   = 0;
      exp_q.delete();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single held digit press.
      press(3'b001, 4'hA, 0, 20);
      chk("digit_A", entry, 32'h0000000A);

      // Nine digits wrap the top nibbles out, then submit.
      press(3'b100, 4'h0, 0, 1);
      for (int d = 1; d <= 9; d++) press(3'b001, 4'(d), 0, 1);
      chk("wrap_entry", entry, 32'h23456789);
      press(3'b010, 4'h0, 0, 2);
      chk("submit_data", data, 32'h23456789);
      chk("submit_entry", entry, 32'h0);

      // Overrun, clear keeps the pending word, then consume.
      press(3'b001, 4'h5, 0, 1);
      press(3'b010, 4'h0, 0, 1);
      chk("overrun_set", {31'b0, overrun}, 32'd1);
      chk("overrun_data", data, 32'h23456789);
      press(3'b100, 4'h0, 0, 1);
      chk("clear_keeps_valid", {31'b0, data_valid}, 32'd1);
      consume();

      // Enter coincident with a handshake reloads without overrun.
      press(3'b001, 4'h7, 0, 1);
      press(3'b010, 4'h0, 0, 1);
      press(3'b001, 4'h8, 0, 1);
      press(3'b010, 4'h0, 1, 1);
      chk("coincident_data", data, 32'h8);
      chk("coincident_overrun", {31'b0, overrun}, 32'd0);
      consume();

      // Bouncing digit key: only the final stable press counts.
      for (int b = 0; b < 5; b++) begin
         @(posedge clk); #1;
         key_digit = 1'b0;
         @(posedge clk); @(posedge clk); #1;
         key_digit = 1'b1;
         @(posedge clk);
      end
      #1;
      chk("bounce_no_event", entry, m_entry);
      press(3'b001, 4'h3, 0, 1);

      // Random key combinations, switch values and consumer timing.
      for (int i = 0; i < 40; i++) begin
         press(3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)),
               bit'($urandom_range(0, 1)), $urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) consume();
      end

      // Reset while FULL with enter held: one enter event after the full latency.
      if (!m_valid) press(3'b010, 4'h0, 0, 1);
      @(posedge clk); #1;
      key_enter = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all("midreset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_first_valid", {31'b0, data_valid}, 32'd0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("reset_early_valid", {31'b0, data_valid}, 32'd0);
      @(posedge clk); #1;
      model_event(3'b010, 4'h0, 0);
      chk_all("reset_enter");
      key_enter = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk_all("reset_release");
      consume();
      repeat (2) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
